light_show_ctrl: RTL

Sequencer for the holiday-light LED shifter. Turns the raw pushbutton and the 3-bit mode switches into clean start/pause/resume commands. Generates the pattern seed, the timed step pulses and the bounce direction that drive the 16-bit LED shift register. It sits between the board I/O and the LED datapath, and is the only block that decides when the datapath loads or moves.

---
 rtl/light_show_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/light_show_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/light_show_pkg.sv
// Shared types and helpers for the holiday-light sequencer: FSM encoding,
// LED width, seed pattern and bounce limit derived from the mode switches.
package light_show_pkg;

    localparam int LED_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    // Seed is a solid block of mode+1 ones starting at bit 0.
    function automatic logic [LED_W-1:0] seed(input logic [2:0] m);
        logic [LED_W-1:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (i <= int'(m)) p[i] = 1'b1;
        end
        return p;
    endfunction

    // Number of steps before the lit block touches the far end of the register.
    function automatic logic [3:0] bounce_limit(input logic [2:0] m);
        return 4'd15 - {1'b0, m};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and
// rising-edge detector producing one registered pulse per accepted press.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= button;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any bounce back to the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/light_show_ctrl.sv
// Holiday-light sequencer: turns button presses and mode switches into
// load/step/direction commands for the 16-bit LED shift register.
module light_show_ctrl
    import light_show_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button,
    input  logic [2:0]  mode,
    output logic        led_load,
    output logic [15:0] led_pattern,
    output logic        led_step,
    output logic        led_dir,
    output logic [1:0]  state
);

    localparam int PW = $clog2(TICK_DIV);

    logic          press;
    logic [2:0]    mode_s1;
    logic [2:0]    mode_s2;
    logic [2:0]    mode_q;
    logic          mchg;
    logic          wrap;
    logic [PW-1:0] presc;
    logic [3:0]    step_cnt;
    state_t        st;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .button (button),
        .press  (press)
    );

    assign mchg  = (mode_s2 != mode_q);
    assign wrap  = (presc == PW'(TICK_DIV - 1));
    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1     <= 3'd0;
            mode_s2     <= 3'd0;
            mode_q      <= 3'd0;
            presc       <= '0;
            step_cnt    <= 4'd0;
            st          <= IDLE;
            led_load    <= 1'b0;
            led_pattern <= 16'h0001;
            led_step    <= 1'b0;
            led_dir     <= 1'b0;
        end else begin
            mode_s1  <= mode;
            mode_s2  <= mode_s1;
            led_load <= 1'b0;
            led_step <= 1'b0;
            if (mchg) mode_q <= mode_s2;

            // Bounce bookkeeping for the step currently on the output.
            if (led_step) begin
                if (step_cnt + 4'd1 == bounce_limit(mode_q)) begin
                    step_cnt <= 4'd0;
                    led_dir  <= ~led_dir;
                end else begin
                    step_cnt <= step_cnt + 4'd1;
                end
            end

            case (st)
                IDLE: begin
                    if (press) begin
                        st          <= LOAD;
                        led_load    <= 1'b1;
                        led_pattern <= seed(mode_s2);
                        presc       <= '0;
                        step_cnt    <= 4'd0;
                        led_dir     <= 1'b0;
                    end
                end
                LOAD: begin
                    // The load cycle is the first period cycle, so the first
                    // step lands TICK_DIV cycles after it.
                    st    <= RUN;
                    presc <= presc + PW'(1);
                end
                RUN: begin
                    if (press) begin
                        st <= PAUSE;
                    end else if (wrap) begin
                        presc    <= '0;
                        led_step <= 1'b1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                PAUSE: begin
                    if (press) st <= RUN;
                end
            endcase

            // A mode change reloads the datapath and overrides any pending step.
            if (mchg && st != IDLE) begin
                led_load    <= 1'b1;
                led_pattern <= seed(mode_s2);
                led_step    <= 1'b0;
                presc       <= '0;
                step_cnt    <= 4'd0;
                led_dir     <= 1'b0;
            end
        end
    end

endmodule
